// File: rtl/vc_arb_pkg.sv
// vc_arb_pkg: shared defaults and index type for the VC output arbiter
package vc_arb_pkg;
  localparam int NUM_VC_DEF = 4;
  localparam int DATA_W_DEF = 6;
  localparam int CNT_W_DEF  = 16;
  localparam int VC_IDX_W   = 3;
  typedef logic [VC_IDX_W-1:0] vc_idx_t;
endpackage

// File: rtl/vc_output_arbiter_rr_prio_sel.sv
// rr_prio_sel: one-hot grant to the first request at or after base, wrapping
module rr_prio_sel
  import vc_arb_pkg::*;
#(
  parameter int N = NUM_VC_DEF
) (
  input  logic [N-1:0] req,
  input  vc_idx_t      base,
  output logic [N-1:0] gnt
);
  localparam int IW = $clog2(N);
  logic [IW-1:0] idx;
  logic          found;
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = IW'((int'(base) + k) % N);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/vc_output_arbiter.sv
// vc_output_arbiter: pops one VC source FIFO per cycle into a registered output stage.
// Define VC_ARB_RR_EN for round-robin selection; default is fixed lowest-index priority.
module vc_output_arbiter
  import vc_arb_pkg::*;
#(
  parameter int NUM_VC = NUM_VC_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                      clk,
  input  logic                      reset_L,
  input  logic [NUM_VC-1:0]         fifo_empty_vc,
  input  logic [NUM_VC*DATA_W-1:0]  fifo_data_vc,
  input  logic [NUM_VC-1:0]         fifo_pause_d,
  output logic [NUM_VC-1:0]         pop_vc,
  output logic [DATA_W-1:0]         data_out,
  output logic                      valid_out,
  output logic [$clog2(NUM_VC)-1:0] vc_out,
  output logic [CNT_W-1:0]          pop_count
);
  localparam int IW = $clog2(NUM_VC);
`ifdef VC_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic [IW-1:0]     last_grant, gidx;
  logic [NUM_VC-1:0] req, gnt;
  logic [DATA_W-1:0] gdata;
  vc_idx_t           base;
  // any downstream pause blocks every VC, even one that just became non-empty
  assign req  = (|fifo_pause_d) ? '0 : ~fifo_empty_vc;
  assign base = RR ? vc_idx_t'(last_grant) + vc_idx_t'(1) : '0;
  rr_prio_sel #(.N(NUM_VC)) u_sel (
    .req  (req),
    .base (base),
    .gnt  (gnt)
  );
  assign pop_vc = reset_L ? gnt : '0;
  always_comb begin
    gidx  = '0;
    gdata = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      if (pop_vc[i]) begin
        gidx  = IW'(i);
        gdata = fifo_data_vc[i*DATA_W +: DATA_W];
      end
    end
  end
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      data_out   <= '0;
      valid_out  <= 1'b0;
      vc_out     <= '0;
      pop_count  <= '0;
      last_grant <= IW'(NUM_VC - 1);
    end else begin
      valid_out <= |pop_vc;
      if (|pop_vc) begin
        data_out   <= gdata;
        vc_out     <= gidx;
        last_grant <= gidx;
        if (pop_count != '1) pop_count <= pop_count + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_vc_output_arbiter.sv
// tb_vc_output_arbiter: directed checks of reset, selection, pause, saturation and mid-stream reset
module tb_vc_output_arbiter;
`ifdef VC_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        reset_L = 1'b0;
  logic [3:0]  fifo_empty_vc = 4'h0;
  logic [23:0] fifo_data_vc = {6'd13, 6'd12, 6'd11, 6'd10};
  logic [3:0]  fifo_pause_d = 4'h0;
  logic [3:0]  pop_vc, s_pop_vc;
  logic [5:0]  data_out, s_data_out;
  logic        valid_out, s_valid_out;
  logic [1:0]  vc_out, s_vc_out;
  logic [15:0] pop_count;
  logic [2:0]  s_pop_count;
  int errors = 0, checks = 0;
  int e, last_vc;

  always #5 clk = ~clk;

  vc_output_arbiter dut (
    .clk(clk), .reset_L(reset_L), .fifo_empty_vc(fifo_empty_vc), .fifo_data_vc(fifo_data_vc),
    .fifo_pause_d(fifo_pause_d), .pop_vc(pop_vc), .data_out(data_out), .valid_out(valid_out),
    .vc_out(vc_out), .pop_count(pop_count)
  );

  vc_output_arbiter #(.CNT_W(3)) dut_sat (
    .clk(clk), .reset_L(reset_L), .fifo_empty_vc(fifo_empty_vc), .fifo_data_vc(fifo_data_vc),
    .fifo_pause_d(fifo_pause_d), .pop_vc(s_pop_vc), .data_out(s_data_out), .valid_out(s_valid_out),
    .vc_out(s_vc_out), .pop_count(s_pop_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_pop", 32'(pop_vc), 32'h0);
    check("rst_valid", 32'(valid_out), 32'h0);
    check("rst_count", 32'(pop_count), 32'h0);
    check("rst_data", 32'(data_out), 32'h0);
    check("rst_vc", 32'(vc_out), 32'h0);
    reset_L = 1'b1;
    #1;
    for (int c = 0; c < 10; c++) begin
      e = RR ? c % 4 : 0;
      check("run_pop", 32'(pop_vc), 32'(4'b0001 << e));
      @(posedge clk);
      #1;
      check("run_valid", 32'(valid_out), 32'h1);
      check("run_vc", 32'(vc_out), 32'(e));
      check("run_data", 32'(data_out), 32'(10 + e));
    end
    last_vc = RR ? 1 : 0;
    check("count10", 32'(pop_count), 32'd10);
    check("sat_count", 32'(s_pop_count), 32'd7);
    fifo_empty_vc = 4'hF;
    #1;
    check("empty_pop", 32'(pop_vc), 32'h0);
    @(posedge clk);
    #1;
    check("empty_valid", 32'(valid_out), 32'h0);
    check("empty_vc_hold", 32'(vc_out), 32'(last_vc));
    check("empty_data_hold", 32'(data_out), 32'(10 + last_vc));
    check("empty_count", 32'(pop_count), 32'd10);
    fifo_empty_vc = 4'b1101;
    fifo_pause_d = 4'b0100;
    repeat (2) begin
      #1;
      check("pause_pop", 32'(pop_vc), 32'h0);
      @(posedge clk);
      #1;
      check("pause_valid", 32'(valid_out), 32'h0);
    end
    fifo_pause_d = 4'h0;
    #1;
    check("unpause_pop", 32'(pop_vc), 32'b0010);
    @(posedge clk);
    #1;
    check("unpause_valid", 32'(valid_out), 32'h1);
    check("unpause_vc", 32'(vc_out), 32'd1);
    check("unpause_data", 32'(data_out), 32'd11);
    check("unpause_count", 32'(pop_count), 32'd11);
    check("sat_hold", 32'(s_pop_count), 32'd7);
    fifo_empty_vc = 4'h0;
    #1;
    e = RR ? 2 : 0;
    check("pre_rst_pop", 32'(pop_vc), 32'(4'b0001 << e));
    @(posedge clk);
    #1;
    check("pre_rst_vc", 32'(vc_out), 32'(e));
    reset_L = 1'b0;
    #1;
    check("mid_rst_valid", 32'(valid_out), 32'h0);
    check("mid_rst_pop", 32'(pop_vc), 32'h0);
    check("mid_rst_count", 32'(pop_count), 32'h0);
    check("mid_rst_data", 32'(data_out), 32'h0);
    #1;
    reset_L = 1'b1;
    #1;
    check("post_rst_pop", 32'(pop_vc), 32'b0001);
    @(posedge clk);
    #1;
    check("post_rst_valid", 32'(valid_out), 32'h1);
    check("post_rst_vc", 32'(vc_out), 32'd0);
    check("post_rst_data", 32'(data_out), 32'd10);
    check("post_rst_count", 32'(pop_count), 32'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
